// File: rtl/paint_pkg.sv
// Shared definitions for the paint block: default geometry and stamp FSM encoding.
// No ports; imported by cursor_brush_ctrl and brush_stamper.
package paint_pkg;

  localparam int W_RES_D   = 640;
  localparam int H_RES_D   = 480;
  localparam int COORD_W_D = 11;
  localparam int COLOR_W_D = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    STAMP = 1'b1
  } stamp_state_t;

endpackage

// File: rtl/brush_stamper.sv
// Square brush stamper: latches origin/size/colour on start and emits a
// row-major pixel stream over a valid/ready handshake.
// Ports: clock, reset (sync, active low), start/start_ack, cursor_x/y,
// brush_sel, color in; wr_valid/wr_x/wr_y/wr_color/busy out, wr_ready in.
module brush_stamper
  import paint_pkg::*;
#(
  parameter int W_RES     = W_RES_D,
  parameter int H_RES     = H_RES_D,
  parameter int COORD_W   = COORD_W_D,
  parameter int CW        = 3 * COLOR_W_D,
  parameter int BASE_SIZE = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  output logic               start_ack,
  input  logic [COORD_W-1:0] cursor_x,
  input  logic [COORD_W-1:0] cursor_y,
  input  logic [1:0]         brush_sel,
  input  logic [CW-1:0]      color,
  input  logic               wr_ready,
  output logic               wr_valid,
  output logic [COORD_W-1:0] wr_x,
  output logic [COORD_W-1:0] wr_y,
  output logic [CW-1:0]      wr_color,
  output logic               busy
);

  stamp_state_t state, nxt;

  logic [COORD_W-1:0] sz, xlim, ylim, ox, oy;
  logic [COORD_W-1:0] x0, xl, yl;
  logic               last;

  assign sz   = COORD_W'(BASE_SIZE) << brush_sel;
  assign xlim = COORD_W'(W_RES) - sz;
  assign ylim = COORD_W'(H_RES) - sz;
  assign ox   = (cursor_x > xlim) ? xlim : cursor_x;
  assign oy   = (cursor_y > ylim) ? ylim : cursor_y;

  assign last      = (wr_x == xl) && (wr_y == yl);
  assign start_ack = (state == IDLE) && start;
  assign wr_valid  = (state == STAMP);
  assign busy      = (state == STAMP);

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (start) nxt = STAMP;
      STAMP: if (wr_ready && last) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      x0       <= '0;
      xl       <= '0;
      yl       <= '0;
      wr_x     <= '0;
      wr_y     <= '0;
      wr_color <= '0;
    end else if (start_ack) begin
      x0       <= ox;
      wr_x     <= ox;
      wr_y     <= oy;
      xl       <= ox + sz - COORD_W'(1);
      yl       <= oy + sz - COORD_W'(1);
      wr_color <= color;
    end else if (state == STAMP && wr_ready) begin
      if (wr_x == xl) begin
        wr_x <= x0;
        wr_y <= wr_y + COORD_W'(1);
      end else begin
        wr_x <= wr_x + COORD_W'(1);
      end
    end
  end

endmodule

// File: rtl/cursor_brush_ctrl.sv
// Cursor/colour controller for a paint canvas: button-driven cursor with
// tick auto-repeat, per-channel colour stepping, and brush stamp requests.
// Ports: clock, reset (sync, active low), buttons, sw_inc/sw_dec, brush_sel,
// paint_en, wr_ready in; cursor_x/y, color, wr_* pixel stream, busy out.
module cursor_brush_ctrl
  import paint_pkg::*;
#(
  parameter int W_RES      = W_RES_D,
  parameter int H_RES      = H_RES_D,
  parameter int COORD_W    = COORD_W_D,
  parameter int COLOR_W    = COLOR_W_D,
  parameter int NCH        = 3,
  parameter int BASE_SIZE  = 8,
  parameter int STEP       = 4,
  parameter int COLOR_STEP = 8,
  parameter int TICK_DIV   = 2000000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     up_n,
  input  logic                     down_n,
  input  logic                     left_n,
  input  logic                     right_n,
  input  logic [NCH-1:0]           sw_inc,
  input  logic [NCH-1:0]           sw_dec,
  input  logic [1:0]               brush_sel,
  input  logic                     paint_en,
  input  logic                     wr_ready,
  output logic [COORD_W-1:0]       cursor_x,
  output logic [COORD_W-1:0]       cursor_y,
  output logic [NCH*COLOR_W-1:0]   color,
  output logic                     wr_valid,
  output logic [COORD_W-1:0]       wr_x,
  output logic [COORD_W-1:0]       wr_y,
  output logic [NCH*COLOR_W-1:0]   wr_color,
  output logic                     busy
);

  localparam int CW = NCH * COLOR_W;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [COORD_W:0] STEP_W = (COORD_W+1)'(STEP);
  localparam logic [COORD_W:0] XMAX   = (COORD_W+1)'(W_RES - 1);
  localparam logic [COORD_W:0] YMAX   = (COORD_W+1)'(H_RES - 1);
  localparam logic [COLOR_W:0] CSTEP  = (COLOR_W+1)'(COLOR_STEP);
  localparam logic [COLOR_W:0] CMAX   = {1'b0, {COLOR_W{1'b1}}};

  localparam logic [COORD_W-1:0] X_RST = COORD_W'((W_RES - BASE_SIZE) / 2);
  localparam logic [COORD_W-1:0] Y_RST = COORD_W'((H_RES - BASE_SIZE) / 2);

  logic [TW-1:0] tcnt;
  logic          tick;

  assign tick = (tcnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clock) begin
    if (!reset)    tcnt <= '0;
    else if (tick) tcnt <= '0;
    else           tcnt <= tcnt + TW'(1);
  end

  logic [COORD_W:0]   xw, yw, x_sum, y_sum;
  logic [COORD_W-1:0] x_nx, y_nx;

  // Opposing buttons cancel; sums carry one extra bit so clamping is exact.
  always_comb begin
    xw    = {1'b0, cursor_x};
    yw    = {1'b0, cursor_y};
    x_sum = xw + STEP_W;
    y_sum = yw + STEP_W;
    x_nx  = cursor_x;
    y_nx  = cursor_y;
    if (tick) begin
      if (!up_n && down_n)
        y_nx = (yw < STEP_W) ? '0 : COORD_W'(yw - STEP_W);
      else if (up_n && !down_n)
        y_nx = (y_sum > YMAX) ? COORD_W'(YMAX) : COORD_W'(y_sum);
      if (!left_n && right_n)
        x_nx = (xw < STEP_W) ? '0 : COORD_W'(xw - STEP_W);
      else if (left_n && !right_n)
        x_nx = (x_sum > XMAX) ? COORD_W'(XMAX) : COORD_W'(x_sum);
    end
  end

  logic [NCH-1:0] inc_q, dec_q, inc_f, dec_f;
  logic [CW-1:0]  col_nx;
  logic [COLOR_W:0] ch, ch_sum;

  assign inc_f = inc_q & ~sw_inc;
  assign dec_f = dec_q & ~sw_dec;

  always_comb begin
    col_nx = color;
    ch     = '0;
    ch_sum = '0;
    for (int i = 0; i < NCH; i++) begin
      ch     = {1'b0, color[i*COLOR_W +: COLOR_W]};
      ch_sum = ch + CSTEP;
      if (inc_f[i] && !dec_f[i])
        col_nx[i*COLOR_W +: COLOR_W] =
          (ch_sum > CMAX) ? CMAX[COLOR_W-1:0] : ch_sum[COLOR_W-1:0];
      else if (dec_f[i] && !inc_f[i])
        col_nx[i*COLOR_W +: COLOR_W] =
          (ch < CSTEP) ? '0 : COLOR_W'(ch - CSTEP);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cursor_x <= X_RST;
      cursor_y <= Y_RST;
      color    <= '0;
      inc_q    <= '0;
      dec_q    <= '0;
    end else begin
      cursor_x <= x_nx;
      cursor_y <= y_nx;
      color    <= col_nx;
      inc_q    <= sw_inc;
      dec_q    <= sw_dec;
    end
  end

  logic               paint_q, pending, rise, moved;
  logic               start_req, start_ack;
  logic               last_vld;
  logic [COORD_W-1:0] last_x, last_y;

  assign rise  = paint_en && !paint_q;
  assign moved = !last_vld || (cursor_x != last_x) || (cursor_y != last_y);
  assign start_req = paint_en && (pending || rise || moved);

  always_ff @(posedge clock) begin
    if (!reset) begin
      paint_q  <= 1'b0;
      pending  <= 1'b0;
      last_vld <= 1'b0;
      last_x   <= '0;
      last_y   <= '0;
    end else begin
      paint_q <= paint_en;
      if (start_ack) begin
        pending  <= 1'b0;
        last_vld <= 1'b1;
        last_x   <= cursor_x;
        last_y   <= cursor_y;
      end else if (!paint_en) begin
        pending <= 1'b0;
      end else if (rise) begin
        pending <= 1'b1;
      end
    end
  end

  brush_stamper #(
    .W_RES    (W_RES),
    .H_RES    (H_RES),
    .COORD_W  (COORD_W),
    .CW       (CW),
    .BASE_SIZE(BASE_SIZE)
  ) u_stamp (
    .clock    (clock),
    .reset    (reset),
    .start    (start_req),
    .start_ack(start_ack),
    .cursor_x (cursor_x),
    .cursor_y (cursor_y),
    .brush_sel(brush_sel),
    .color    (color),
    .wr_ready (wr_ready),
    .wr_valid (wr_valid),
    .wr_x     (wr_x),
    .wr_y     (wr_y),
    .wr_color (wr_color),
    .busy     (busy)
  );

endmodule

// File: tb/tb_cursor_brush_ctrl.sv
// Directed bench for cursor_brush_ctrl with a pixel scoreboard.
// Runs with TICK_DIV=4 so one movement tick is four clock cycles.
module tb_cursor_brush_ctrl;

  logic        clock;
  logic        reset;
  logic        up_n, down_n, left_n, right_n;
  logic [2:0]  sw_inc, sw_dec;
  logic [1:0]  brush_sel;
  logic        paint_en;
  logic        wr_ready;
  logic [10:0] cursor_x, cursor_y;
  logic [23:0] color;
  logic        wr_valid;
  logic [10:0] wr_x, wr_y;
  logic [23:0] wr_color;
  logic        busy;

  cursor_brush_ctrl #(.TICK_DIV(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .up_n     (up_n),
    .down_n   (down_n),
    .left_n   (left_n),
    .right_n  (right_n),
    .sw_inc   (sw_inc),
    .sw_dec   (sw_dec),
    .brush_sel(brush_sel),
    .paint_en (paint_en),
    .wr_ready (wr_ready),
    .cursor_x (cursor_x),
    .cursor_y (cursor_y),
    .color    (color),
    .wr_valid (wr_valid),
    .wr_x     (wr_x),
    .wr_y     (wr_y),
    .wr_color (wr_color),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          x;
    int          y;
    logic [23:0] c;
  } px_t;

  px_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse(input logic [2:0] inc, input logic [2:0] dec);
    sw_inc = inc;
    sw_dec = dec;
    step();
    sw_inc = '0;
    sw_dec = '0;
    step();
  endtask

  task automatic push_stamp(input int x0, input int y0, input int s,
                            input logic [23:0] c);
    for (int r = 0; r < s; r++)
      for (int q = 0; q < s; q++)
        sb.push_back('{x0 + q, y0 + r, c});
  endtask

  // mode 0: ready held high; mode 1: ready alternates starting low
  task automatic drain(input int mode, input int budget, input int max_x,
                       output int ncyc);
    int          n;
    logic        stall;
    logic [10:0] px, py;
    logic [23:0] pc;
    px_t         e;
    n     = 0;
    stall = 1'b0;
    px    = '0;
    py    = '0;
    pc    = '0;
    ncyc  = 0;
    while (sb.size() > 0 && n < max_x && ncyc < budget) begin
      wr_ready = (mode == 0) ? 1'b1 : ncyc[0];
      if (stall) begin
        chk("stall_valid", 32'(wr_valid), 32'd1);
        chk("stall_x", 32'(wr_x), 32'(px));
        chk("stall_y", 32'(wr_y), 32'(py));
        chk("stall_col", 32'(wr_color), 32'(pc));
      end
      if (wr_valid && wr_ready) begin
        e = sb.pop_front();
        chk("wr_x", 32'(wr_x), 32'(e.x));
        chk("wr_y", 32'(wr_y), 32'(e.y));
        chk("wr_col", 32'(wr_color), 32'(e.c));
        n++;
      end
      stall = wr_valid && !wr_ready;
      px    = wr_x;
      py    = wr_y;
      pc    = wr_color;
      step();
      ncyc++;
    end
    chk("drain_count", 32'(n), 32'(max_x));
  endtask

  initial begin
    reset     = 1'b1;
    up_n      = 1'b1;
    down_n    = 1'b1;
    left_n    = 1'b1;
    right_n   = 1'b1;
    sw_inc    = '0;
    sw_dec    = '0;
    brush_sel = 2'd0;
    paint_en  = 1'b0;
    wr_ready  = 1'b0;
    #2;

    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("rst_x", 32'(cursor_x), 32'd316);
    chk("rst_y", 32'(cursor_y), 32'd236);
    chk("rst_col", 32'(color), 32'd0);
    chk("rst_valid", 32'(wr_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    up_n = 1'b0;
    repeat (12) step();
    up_n = 1'b1;
    chk("up3_y", 32'(cursor_y), 32'd224);
    chk("up3_x", 32'(cursor_x), 32'd316);

    left_n = 1'b0;
    repeat (312) step();
    chk("left_to4", 32'(cursor_x), 32'd4);
    repeat (4) step();
    chk("left_4to0", 32'(cursor_x), 32'd0);
    repeat (4) step();
    chk("left_clamp0", 32'(cursor_x), 32'd0);
    left_n = 1'b1;

    up_n   = 1'b0;
    down_n = 1'b0;
    repeat (8) step();
    up_n   = 1'b1;
    down_n = 1'b1;
    chk("updown_y", 32'(cursor_y), 32'd224);

    up_n    = 1'b0;
    right_n = 1'b0;
    repeat (4) step();
    up_n    = 1'b1;
    right_n = 1'b1;
    chk("diag_x", 32'(cursor_x), 32'd4);
    chk("diag_y", 32'(cursor_y), 32'd220);

    sw_inc = 3'b001;
    repeat (3) step();
    sw_inc = '0;
    step();
    chk("inc_first", 32'(color), 32'h000008);
    repeat (30) pulse(3'b001, 3'b000);
    chk("inc_to248", 32'(color), 32'h0000F8);
    pulse(3'b001, 3'b000);
    chk("inc_clamp", 32'(color), 32'h0000FF);
    repeat (31) pulse(3'b000, 3'b001);
    chk("dec_to7", 32'(color), 32'h000007);
    pulse(3'b000, 3'b001);
    chk("dec_clamp", 32'(color), 32'h000000);
    pulse(3'b001, 3'b000);
    pulse(3'b001, 3'b001);
    chk("incdec_same", 32'(color), 32'h000008);
    pulse(3'b110, 3'b000);
    chk("multi_ch", 32'(color), 32'h080808);

    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("rst2_col", 32'(color), 32'd0);
    pulse(3'b001, 3'b000);

    wr_ready = 1'b1;
    paint_en = 1'b1;
    push_stamp(316, 236, 8, 24'h000008);
    drain(0, 200, 64, cyc);
    chk("stamp_cycles", 32'(cyc), 32'd65);
    chk("stamp_busy", 32'(busy), 32'd0);
    chk("stamp_valid", 32'(wr_valid), 32'd0);
    step();
    chk("no_restamp", 32'(busy), 32'd0);
    paint_en = 1'b0;
    step();

    pulse(3'b100, 3'b000);
    wr_ready = 1'b0;
    paint_en = 1'b1;
    push_stamp(316, 236, 8, 24'h080008);
    step();
    chk("toggle_busy", 32'(busy), 32'd1);
    brush_sel = 2'd2;
    drain(1, 400, 64, cyc);
    chk("toggle_done", 32'(busy), 32'd0);
    brush_sel = 2'd0;
    paint_en  = 1'b0;
    step();

    right_n = 1'b0;
    down_n  = 1'b0;
    repeat (400) step();
    right_n = 1'b1;
    down_n  = 1'b1;
    chk("clamp_x", 32'(cursor_x), 32'd639);
    chk("clamp_y", 32'(cursor_y), 32'd479);

    brush_sel = 2'd3;
    paint_en  = 1'b1;
    push_stamp(576, 416, 64, 24'h080008);
    drain(0, 5000, 4096, cyc);
    chk("big_done", 32'(busy), 32'd0);
    paint_en  = 1'b0;
    brush_sel = 2'd0;
    step();

    paint_en = 1'b1;
    push_stamp(632, 472, 8, 24'h080008);
    drain(0, 100, 10, cyc);
    sb.delete();
    reset    = 1'b0;
    paint_en = 1'b0;
    step();
    reset = 1'b1;
    chk("abort_valid", 32'(wr_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_x", 32'(cursor_x), 32'd316);
    chk("abort_y", 32'(cursor_y), 32'd236);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("abort_quiet", 32'(wr_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
